fir_coeff_loader: RTL and testbench

Coefficient writer for the 32-tap transposed-form FIR filter. It accepts a stream of 16-bit coefficient words over a valid/ready interface and assembles them in a shadow bank. After a complete, correctly framed set has been received, it atomically commits that set to the active bank. The active bank drives the filter's `coefficients` port directly, so the filter never sees a partially written set.

---
 rtl/fir_coeff_loader.sv | 85 ++++++++
 tb/tb_fir_coeff_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_loader.sv
// Coefficient loader for the transposed-form FIR: collects one framed set of
// NUMTAPS words in a shadow bank and commits it to the active bank in one edge.
module fir_coeff_loader #(
  parameter int NUMTAPS = 32,
  parameter int COEFF_W = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [COEFF_W-1:0]              wr_data,
  input  logic                            wr_last,
  output logic [NUMTAPS-1:0][COEFF_W-1:0] coefficients,
  output logic                            coeff_update,
  output logic                            load_err,
  output logic                            busy
);

  localparam int IDX_W = (NUMTAPS > 1) ? $clog2(NUMTAPS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUMTAPS - 1);
  localparam logic [COEFF_W-1:0] UNITY    = {1'b0, {(COEFF_W-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, DRAIN} state_t;

  state_t                            state;
  logic [IDX_W-1:0]                  idx;
  logic [NUMTAPS-1:0][COEFF_W-1:0]   shadow;
  logic                              hs;

  assign wr_ready = (state != COMMIT);
  assign busy     = (state != IDLE);
  assign hs       = wr_valid && wr_ready;

  // Shadow bank is only read during COMMIT, so it needs no reset.
  always_ff @(posedge clk) begin
    if (hs && (state == IDLE || state == LOAD))
      shadow[idx] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      coeff_update    <= 1'b0;
      load_err        <= 1'b0;
      coefficients    <= '0;
      coefficients[0] <= UNITY;
    end else begin
      coeff_update <= 1'b0;
      load_err     <= 1'b0;
      case (state)
        // IDLE is simply LOAD at idx 0, so both share the framing decision.
        IDLE, LOAD: begin
          if (hs) begin
            if (idx == LAST_IDX) begin
              state <= wr_last ? COMMIT : DRAIN;
            end else if (wr_last) begin
              load_err <= 1'b1;
              idx      <= '0;
              state    <= IDLE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= LOAD;
            end
          end
        end
        COMMIT: begin
          coefficients <= shadow;
          coeff_update <= 1'b1;
          idx          <= '0;
          state        <= IDLE;
        end
        DRAIN: begin
          if (hs && wr_last) begin
            load_err <= 1'b1;
            idx      <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomized bench for fir_coeff_loader against a frame-level reference model.
module tb_fir_coeff_loader;
  localparam int NT = 32;
  localparam int CW = 16;
  localparam int VW = NT * CW;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      wr_valid;
  logic                      wr_ready;
  logic [CW-1:0]             wr_data;
  logic                      wr_last;
  logic [NT-1:0][CW-1:0]     coefficients;
  logic                      coeff_update;
  logic                      load_err;
  logic                      busy;

  fir_coeff_loader #(.NUMTAPS(NT), .COEFF_W(CW)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_last(wr_last), .coefficients(coefficients),
    .coeff_update(coeff_update), .load_err(load_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: a set is just the list of words between two wr_last marks.
  logic [NT-1:0][CW-1:0] exp_bank, pending, rst_bank, want;
  logic [CW-1:0]         frame_q[$];
  int                    cnt;
  logic                  in_commit, exp_update, exp_err;

  int n_hs, n_upd, n_err, n_rdy_low, edge_no, first_hs_edge, upd_edge;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_bank = rst_bank;
    frame_q.delete();
    cnt = 0;
    in_commit = 1'b0;
    exp_update = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic clear_stats();
    n_hs = 0; n_upd = 0; n_err = 0; n_rdy_low = 0;
    first_hs_edge = -1; upd_edge = -1;
  endtask

  task automatic model_step(input logic hs, input logic [CW-1:0] d, input logic l);
    exp_update = in_commit;
    exp_err = 1'b0;
    if (in_commit) begin
      exp_bank = pending;
      in_commit = 1'b0;
    end
    if (hs) begin
      if (frame_q.size() < NT) frame_q.push_back(d);
      cnt++;
      if (l) begin
        if (cnt == NT) begin
          for (int i = 0; i < NT; i++) pending[i] = frame_q[i];
          in_commit = 1'b1;
        end else begin
          exp_err = 1'b1;
        end
        cnt = 0;
        frame_q.delete();
      end
    end
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] d, input logic l, output logic hs);
    wr_valid = v; wr_data = d; wr_last = l;
    @(posedge clk);
    hs = v && !in_commit;
    if (hs) begin
      n_hs++;
      if (first_hs_edge < 0) first_hs_edge = edge_no;
    end
    model_step(hs, d, l);
    #1;
    check("coefficients", coefficients, exp_bank);
    check("coeff_update", coeff_update, exp_update);
    check("load_err", load_err, exp_err);
    check("wr_ready", wr_ready, !in_commit);
    check("busy", busy, in_commit || cnt > 0);
    if (coeff_update) begin n_upd++; upd_edge = edge_no; end
    if (load_err) n_err++;
    if (!wr_ready) n_rdy_low++;
    edge_no++;
  endtask

  task automatic send_word(input logic [CW-1:0] d, input logic l, input bit gaps);
    logic hs;
    int tries;
    hs = 1'b0;
    tries = 0;
    while (!hs) begin
      if (tries > 100) begin
        check("handshake_timeout", 1, 0);
        return;
      end
      if (gaps && $urandom_range(0, 2) == 0) drive(1'b0, 'x, 'x, hs);
      else drive(1'b1, d, l, hs);
      tries++;
    end
  endtask

  task automatic idle(input int n);
    logic hs;
    for (int i = 0; i < n; i++) drive(1'b0, 'x, 'x, hs);
  endtask

  logic hs_dummy;

  initial begin
    rst_bank = '0;
    rst_bank[0] = 16'h7FFF;
    edge_no = 0;
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
    model_reset();
    clear_stats();
    #12;
    check("rst_coefficients", coefficients, rst_bank);
    check("rst_busy", busy, 0);
    check("rst_update", coeff_update, 0);
    check("rst_err", load_err, 0);
    @(negedge clk) rst = 1'b0;
    #1 check("rst_ready", wr_ready, 1);

    // Directed 32-word set, valid held high through the commit cycle.
    clear_stats();
    for (int n = 0; n < NT; n++) send_word(CW'(16'h0100 + n), n == NT - 1, 1'b0);
    drive(1'b1, 16'hDEAD, 1'b0, hs_dummy);
    idle(2);
    for (int n = 0; n < NT; n++) want[n] = CW'(16'h0100 + n);
    check("d1_bank", coefficients, want);
    check("d1_ready_low", n_rdy_low, 1);
    check("d1_updates", n_upd, 1);
    check("d1_latency", upd_edge - first_hs_edge + 1, 33);
    check("d1_hs", n_hs, 32);

    // Short set, then a good set.
    clear_stats();
    for (int n = 0; n < 10; n++) send_word(CW'($urandom), n == 9, 1'b0);
    idle(2);
    check("short_err", n_err, 1);
    check("short_upd", n_upd, 0);
    check("short_bank", coefficients, want);
    for (int n = 0; n < NT; n++) begin
      want[n] = CW'($urandom);
      send_word(want[n], n == NT - 1, 1'b0);
    end
    idle(2);
    check("after_short_bank", coefficients, want);

    // Long set of 40 words.
    clear_stats();
    for (int n = 0; n < 40; n++) send_word(CW'($urandom), n == 39, 1'b0);
    check("long_busy_fall", busy, 0);
    idle(2);
    check("long_hs", n_hs, 40);
    check("long_err", n_err, 1);
    check("long_upd", n_upd, 0);
    check("long_bank", coefficients, want);

    // Alternating extremes with random valid gaps.
    clear_stats();
    for (int n = 0; n < NT; n++) begin
      want[n] = (n % 2 == 0) ? 16'h8000 : 16'h7FFF;
      send_word(want[n], n == NT - 1, 1'b1);
    end
    idle(2);
    check("gap_hs", n_hs, 32);
    check("gap_bank", coefficients, want);
    check("gap_upd", n_upd, 1);

    // Reset in the middle of a set.
    for (int n = 0; n <= 20; n++) send_word(CW'($urandom), 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midrst_bank", coefficients, rst_bank);
    check("midrst_busy", busy, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    model_reset();
    clear_stats();
    idle(3);
    check("midrst_no_pulse", n_upd + n_err, 0);
    for (int n = 0; n < NT; n++) begin
      want[n] = CW'($urandom);
      send_word(want[n], n == NT - 1, 1'b1);
    end
    idle(2);
    check("postrst_bank", coefficients, want);

    // Random framing: short, exact and long sets mixed with random gaps.
    for (int f = 0; f < 16; f++) begin
      int len;
      case ($urandom_range(0, 3))
        0: len = $urandom_range(1, 5);
        1: len = NT;
        2: len = $urandom_range(NT - 1, NT + 1);
        default: len = $urandom_range(1, NT + 8);
      endcase
      for (int n = 0; n < len; n++) send_word(CW'($urandom), n == len - 1, 1'b1);
      idle($urandom_range(0, 3));
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
